axis_join_n: RTL and testbench

AXIS_JOIN_N -- requirements
Module: axis_join_n

---
 rtl/axis_join_n.sv | 118 +++++++++++
 tb/tb_axis_join_n.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_join_n.sv
// Joins N_CH AXI-Stream channels beat-by-beat into one wide output; 1-cycle latency, 1 beat/cycle.
// Each channel has a 2-deep skid FIFO, and s_ready drops when it is full. Optional AXIS_JOIN_LAST_CHECK_EN adds a sticky tlast-mismatch flag.
module axis_join_n #(
    parameter int N_CH = 2,
    parameter int W    = 64,
    parameter int U    = 8
) (
    input  logic              aclk,
    input  logic              rst,
    input  logic [N_CH-1:0]   s_valid,
    output logic [N_CH-1:0]   s_ready,
    input  logic [N_CH*W-1:0] s_data,
    input  logic [N_CH-1:0]   s_last,
    input  logic [U-1:0]      s_user,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [N_CH*W-1:0] m_data,
    output logic              m_last,
    output logic [U-1:0]      m_user,
    output logic [15:0]       pkt_beats,
    output logic              err_last
);

    logic [1:0]      occ      [N_CH];
    logic [1:0]      occ_nxt  [N_CH];
    logic [W-1:0]    mem_data [N_CH][2];
    logic [1:0]      mem_last [N_CH];
    logic [U-1:0]    mem_user [2];
    logic [N_CH-1:0] rptr, wptr;
    logic [N_CH-1:0] push, avail, wr_en, head_last;
    logic [N_CH*W-1:0] head_data;
    logic [U-1:0]    head_user;
    logic            fire;

    // An empty FIFO forwards the incoming beat directly so that a join can
    // fire in the same cycle the beat arrives.
    always_comb begin
        push      = '0;
        avail     = '0;
        head_data = '0;
        head_last = '0;
        for (int i = 0; i < N_CH; i++) begin
            push[i]  = s_valid[i] & s_ready[i];
            avail[i] = (occ[i] != 2'd0) | push[i];
            if (occ[i] != 2'd0) begin
                head_data[i*W +: W] = mem_data[i][rptr[i]];
                head_last[i]        = mem_last[i][rptr[i]];
            end else begin
                head_data[i*W +: W] = s_data[i*W +: W];
                head_last[i]        = s_last[i];
            end
        end
        head_user = (occ[0] != 2'd0) ? mem_user[rptr[0]] : s_user;
        fire      = (&avail) & (~m_valid | m_ready);
        wr_en     = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr_en[i]   = push[i] & ~(fire & (occ[i] == 2'd0));
            occ_nxt[i] = occ[i] + {1'b0, push[i]} - {1'b0, fire};
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) occ[i] <= 2'd0;
            rptr      <= '0;
            wptr      <= '0;
            s_ready   <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            pkt_beats <= 16'd0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                occ[i]     <= occ_nxt[i];
                s_ready[i] <= (occ_nxt[i] != 2'd2);
                if (wr_en[i])
                    wptr[i] <= ~wptr[i];
                if (fire && (occ[i] != 2'd0))
                    rptr[i] <= ~rptr[i];
            end
            if (fire) begin
                m_valid <= 1'b1;
                m_last  <= head_last[0];
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            if (m_valid && m_ready)
                pkt_beats <= m_last ? 16'd0 : pkt_beats + 16'd1;
        end
    end

    // Payload storage carries no reset; its contents are qualified by occ/m_valid.
    always_ff @(posedge aclk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (wr_en[i]) begin
                mem_data[i][wptr[i]] <= s_data[i*W +: W];
                mem_last[i][wptr[i]] <= s_last[i];
            end
        end
        if (wr_en[0])
            mem_user[wptr[0]] <= s_user;
        if (fire) begin
            m_data <= head_data;
            m_user <= head_user;
        end
    end

`ifdef AXIS_JOIN_LAST_CHECK_EN
    always_ff @(posedge aclk) begin
        if (rst)
            err_last <= 1'b0;
        else if (fire && !((&head_last) || (~|head_last)))
            err_last <= 1'b1;
    end
`else
    assign err_last = 1'b0;
`endif

endmodule

// File: tb/tb_axis_join_n.sv
// Randomized and directed bench for axis_join_n, scored against a queue-based model of the joined stream.
module tb_axis_join_n;
    localparam int N_CH = 2;
    localparam int W    = 16;
    localparam int U    = 8;

    logic              aclk = 1'b0;
    logic              rst;
    logic [N_CH-1:0]   s_valid;
    logic [N_CH-1:0]   s_ready;
    logic [N_CH*W-1:0] s_data;
    logic [N_CH-1:0]   s_last;
    logic [U-1:0]      s_user;
    logic              m_valid;
    logic              m_ready;
    logic [N_CH*W-1:0] m_data;
    logic              m_last;
    logic [U-1:0]      m_user;
    logic [15:0]       pkt_beats;
    logic              err_last;

    axis_join_n #(.N_CH(N_CH), .W(W), .U(U)) dut (
        .aclk(aclk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .s_user(s_user),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .m_user(m_user),
        .pkt_beats(pkt_beats), .err_last(err_last)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
        logic [U-1:0] u;
    } beat_t;

    beat_t q [N_CH][$];
    int    acc_cnt [N_CH];
    int    out_cnt;
    int    pkt_model;
    bit    err_model;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N_CH; i++) begin
            q[i].delete();
            acc_cnt[i] = 0;
        end
        out_cnt   = 0;
        pkt_model = 0;
        err_model = 0;
    endtask

    task automatic drive(input logic [N_CH-1:0] v, input logic [N_CH-1:0] l, input logic r);
        s_valid = v;
        s_last  = l;
        m_ready = r;
        for (int i = 0; i < N_CH; i++) s_data[i*W +: W] = W'($urandom);
        s_user = U'($urandom);
    endtask

    // One clock: check outputs against the model, record this cycle's handshakes, advance.
    task automatic step();
        logic [N_CH*W-1:0] exp_d;
        bit any_empty, mm, ohs;
        int occ;
        #1;
        for (int i = 0; i < N_CH; i++) begin
            occ = acc_cnt[i] - out_cnt - (m_valid ? 1 : 0);
            chk("s_ready_vs_occ", s_ready[i], occ < 2);
        end
        any_empty = 0;
        for (int i = 0; i < N_CH; i++) if (q[i].size() == 0) any_empty = 1;
        mm = 0;
        if (m_valid) begin
            if (any_empty) begin
                chk("spurious_m_valid", m_valid, 1'b0);
            end else begin
                exp_d = '0;
                for (int i = 0; i < N_CH; i++) begin
                    exp_d[i*W +: W] = q[i][0].d;
                    if (q[i][0].l != q[0][0].l) mm = 1;
                end
                chk("m_data", m_data, exp_d);
                chk("m_last", m_last, q[0][0].l);
                chk("m_user", m_user, q[0][0].u);
            end
        end
        chk("pkt_beats", pkt_beats, pkt_model);
`ifdef AXIS_JOIN_LAST_CHECK_EN
        chk("err_last", err_last, err_model | (m_valid & mm));
`else
        chk("err_last", err_last, 1'b0);
`endif
        ohs = m_valid & m_ready & !any_empty;
        if (ohs) begin
            pkt_model = q[0][0].l ? 0 : (pkt_model + 1) % 65536;
            err_model = err_model | mm;
            for (int i = 0; i < N_CH; i++) void'(q[i].pop_front());
            out_cnt++;
        end
        for (int i = 0; i < N_CH; i++) begin
            if (s_valid[i] && s_ready[i]) begin
                q[i].push_back('{d: s_data[i*W +: W], l: s_last[i], u: s_user});
                acc_cnt[i]++;
            end
        end
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = '0;
        @(posedge aclk);
        @(negedge aclk);
        #1;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_pkt_beats", pkt_beats, 16'd0);
        chk("rst_err_last", err_last, 1'b0);
        chk("rst_s_ready", s_ready, '0);
        rst = 1'b0;
        model_clear();
        @(posedge aclk);
        @(negedge aclk);
        #1;
        chk("post_rst_s_ready", s_ready, {N_CH{1'b1}});
    endtask

    logic [N_CH*W-1:0] held_d;
    logic              held_l;
    logic [U-1:0]      held_u;

    initial begin
        rst = 1'b1;
        drive('0, '0, 1'b1);
        model_clear();
        do_reset();

        // Back-to-back 4 beats: first output one cycle later, then no bubbles.
        for (int b = 0; b < 4; b++) begin
            drive(2'b11, 2'b00, 1'b1);
            step();
            chk("b2b_m_valid", m_valid, 1'b1);
        end
        drive(2'b00, 2'b00, 1'b1);
        step();
        step();
        chk("b2b_idle", m_valid, 1'b0);

        // Channel 0 runs ahead while channel 1 is idle.
        for (int c = 0; c < 10; c++) begin
            drive(2'b01, 2'b00, 1'b1);
            step();
        end
        chk("ahead_s_ready0", s_ready[0], 1'b0);
        chk("ahead_m_valid", m_valid, 1'b0);
        for (int c = 0; c < 6; c++) begin
            drive(2'b11, 2'b00, 1'b1);
            step();
        end
        drive(2'b00, 2'b00, 1'b1);
        for (int c = 0; c < 4; c++) step();

        // Output stall: payload must hold, then resume at full rate.
        drive(2'b11, 2'b00, 1'b0);
        step();
        held_d = m_data; held_l = m_last; held_u = m_user;
        for (int c = 0; c < 5; c++) begin
            drive(2'b11, 2'b00, 1'b0);
            step();
            chk("stall_m_valid", m_valid, 1'b1);
            chk("stall_m_data", m_data, held_d);
            chk("stall_m_last", m_last, held_l);
            chk("stall_m_user", m_user, held_u);
        end
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, 2'b00, 1'b1);
            step();
            chk("resume_m_valid", m_valid, 1'b1);
        end
        drive(2'b00, 2'b00, 1'b1);
        for (int c = 0; c < 4; c++) step();

        // 3-beat packet with tlast on beat 3.
        for (int b = 1; b <= 3; b++) begin
            drive(2'b11, (b == 3) ? 2'b11 : 2'b00, 1'b1);
            step();
        end
        drive(2'b00, 2'b00, 1'b1);
        for (int c = 0; c < 3; c++) step();
        chk("pkt_end_beats", pkt_beats, 16'd0);

        // Channel 1 tlast one beat early.
        for (int b = 1; b <= 3; b++) begin
            drive(2'b11, {b == 2, b == 3}, 1'b1);
            step();
        end
        drive(2'b00, 2'b00, 1'b1);
        for (int c = 0; c < 3; c++) step();
`ifdef AXIS_JOIN_LAST_CHECK_EN
        chk("err_sticky", err_last, 1'b1);
`else
        chk("err_tied", err_last, 1'b0);
`endif

        // Reset with both buffers full and output held.
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, 2'b00, 1'b0);
            step();
        end
        chk("full_s_ready", s_ready, 2'b00);
        do_reset();

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            logic [N_CH-1:0] v, l;
            for (int i = 0; i < N_CH; i++) begin
                v[i] = ($urandom_range(3) != 0);
                l[i] = ($urandom_range(5) == 0);
            end
            drive(v, l, $urandom_range(3) != 0);
            step();
            if (c == 300) do_reset();
        end
        drive(2'b00, 2'b00, 1'b1);
        for (int c = 0; c < 6; c++) step();
        chk("drain_m_valid", m_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
